jhash_vector_seq: RTL

JHASH_VECTOR_SEQ -- requirements
Module: jhash_vector_seq

---
 rtl/jhash_pkg.sv | 19 +
 rtl/jhash_vector_seq_if.sv | 45 ++++
 rtl/jhash_vector_seq_ram.sv | 26 ++
 rtl/jhash_vector_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/jhash_pkg.sv
// Shared definitions for the jhash vector sequencer: FSM states, timeout default,
// hash length width and a saturating counter helper.
package jhash_pkg;

    localparam int JH_TIMEOUT_DEF = 1024;
    localparam int JH_LEN_W       = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } jh_state_t;

    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/jhash_vector_seq_if.sv
// Bundle of the run-control, table-write, hash-core and status signals.
// slave is the sequencer side, master is the host/core side.
interface jhash_vector_seq_if #(
    parameter int WORD_W = 64,
    parameter int AW     = 4
) ();
    import jhash_pkg::*;

    logic                start;
    logic                loop_en;
    logic [AW:0]         num_words;
    logic [31:0]         exp_hash;
    logic                tbl_we;
    logic [AW-1:0]       tbl_addr;
    logic [WORD_W-1:0]   tbl_wdata;
    logic                hash_ce;
    logic [WORD_W-1:0]   hash_id;
    logic                hash_last;
    logic [JH_LEN_W-1:0] hash_len;
    logic                hash_done;
    logic [31:0]         hash_dout;
    logic                busy;
    logic                pass;
    logic                fail;
    logic                tmo;
    logic                cfg_err;
    logic [31:0]         result;
    logic [7:0]          err_cnt;
    logic [15:0]         run_cnt;

    modport slave (
        input  start, loop_en, num_words, exp_hash, tbl_we, tbl_addr, tbl_wdata,
               hash_done, hash_dout,
        output hash_ce, hash_id, hash_last, hash_len, busy, pass, fail, tmo, cfg_err,
               result, err_cnt, run_cnt
    );

    modport master (
        output start, loop_en, num_words, exp_hash, tbl_we, tbl_addr, tbl_wdata,
               hash_done, hash_dout,
        input  hash_ce, hash_id, hash_last, hash_len, busy, pass, fail, tmo, cfg_err,
               result, err_cnt, run_cnt
    );

endinterface

// File: rtl/jhash_vector_seq_ram.sv
// Vector table: one synchronous write port, one asynchronous read port.
// A same-cycle read of the address being written sees the old word.
module jhash_vec_ram #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jhash_vector_seq.sv
// Sequencer that streams table words into an external hash core, waits for its
// digest with a timeout, compares against the expected value and keeps run statistics.
module jhash_vector_seq
    import jhash_pkg::*;
#(
    parameter int WORD_W    = 64,
    parameter int MAX_WORDS = 16,
    parameter int TIMEOUT   = JH_TIMEOUT_DEF,
    parameter int AW        = $clog2(MAX_WORDS)
) (
    input logic               clk,
    input logic               rst,
    jhash_vector_seq_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    jh_state_t         r_state;
    logic [AW:0]       r_num;
    logic [31:0]       r_exp;
    logic [AW-1:0]     r_idx;
    logic [TW-1:0]     r_wcnt;
    logic              r_pass;
    logic              r_fail;
    logic              r_tmo;
    logic              r_cfgErr;
    logic [31:0]       r_result;
    logic [7:0]        r_errCnt;
    logic [15:0]       r_runCnt;

    logic              w_feed;
    logic              w_idxLast;
    logic              w_cfgOk;
    logic [WORD_W-1:0] w_rdata;

    jhash_vec_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (MAX_WORDS),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (bus.tbl_we),
        .i_waddr (bus.tbl_addr),
        .i_wdata (bus.tbl_wdata),
        .i_raddr (r_idx),
        .o_rdata (w_rdata)
    );

    assign w_feed    = (r_state == ST_FEED);
    assign w_idxLast = ({1'b0, r_idx} == (r_num - {{AW{1'b0}}, 1'b1}));
    assign w_cfgOk   = (bus.num_words != '0) && (bus.num_words <= (AW+1)'(MAX_WORDS));

    // Core-facing strobes decode straight from state so an async reset drops them at once.
    assign bus.hash_ce   = w_feed;
    assign bus.hash_last = w_feed && w_idxLast;
    assign bus.hash_id   = w_feed ? w_rdata : '0;
    assign bus.hash_len  = JH_LEN_W'(r_num);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.pass      = r_pass;
    assign bus.fail      = r_fail;
    assign bus.tmo       = r_tmo;
    assign bus.cfg_err   = r_cfgErr;
    assign bus.result    = r_result;
    assign bus.err_cnt   = r_errCnt;
    assign bus.run_cnt   = r_runCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_num    <= '0;
            r_exp    <= '0;
            r_idx    <= '0;
            r_wcnt   <= '0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_tmo    <= 1'b0;
            r_cfgErr <= 1'b0;
            r_result <= '0;
            r_errCnt <= '0;
            r_runCnt <= '0;
        end else begin
            r_cfgErr <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_cfgOk) begin
                            r_num   <= bus.num_words;
                            r_exp   <= bus.exp_hash;
                            r_idx   <= '0;
                            r_pass  <= 1'b0;
                            r_fail  <= 1'b0;
                            r_tmo   <= 1'b0;
                            r_state <= ST_FEED;
                        end else begin
                            r_cfgErr <= 1'b1;
                        end
                    end
                end
                ST_FEED: begin
                    if (w_idxLast) begin
                        r_wcnt  <= '0;
                        r_state <= ST_WAIT;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A done level already present in the first WAIT cycle is taken immediately.
                    if (bus.hash_done) begin
                        r_result <= bus.hash_dout;
                        r_state  <= ST_CHECK;
                    end else if (r_wcnt == TW'(TIMEOUT - 1)) begin
                        r_tmo    <= 1'b1;
                        r_fail   <= 1'b1;
                        r_pass   <= 1'b0;
                        r_errCnt <= satInc8(r_errCnt);
                        r_state  <= ST_IDLE;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (r_result == r_exp) begin
                        r_pass <= 1'b1;
                        r_fail <= 1'b0;
                    end else begin
                        r_pass   <= 1'b0;
                        r_fail   <= 1'b1;
                        r_errCnt <= satInc8(r_errCnt);
                    end
                    r_runCnt <= r_runCnt + 16'd1;
                    if (bus.loop_en) begin
                        r_idx   <= '0;
                        r_state <= ST_FEED;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
